// File: rtl/dac7611_rx.sv
// Receiver that emulates the DAC7611 serial input latch: synchronizes the
// three-wire bus plus CLR into the clk domain and reconstructs the 12-bit code.
module dac7611_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [11:0] RESET_CODE  = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CLK_3,
  input  logic        SDI_4,
  input  logic        LD_5,
  input  logic        CLR_6,
  output logic [11:0] dac_code,
  output logic        load_strobe,
  output logic        clr_strobe,
  output logic        frame_err,
  output logic [3:0]  bit_cnt
);

  localparam int unsigned CODE_W   = 12;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned NUM_PINS = 4;
  localparam int unsigned PIN_SCK  = 0;
  localparam int unsigned PIN_SDI  = 1;
  localparam int unsigned PIN_LD   = 2;
  localparam int unsigned PIN_CLR  = 3;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(12);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(15);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_q, sync_d;
  logic [NUM_PINS-1:0] pins_s;
  logic [2:0]          dly_q, dly_d;
  state_e              state_q, state_d;
  logic [CODE_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                load_q, load_d;
  logic                clr_q, clr_d;
  logic                err_q, err_d;

  logic sck_s, sdi_s, ld_s, clr_s;
  logic sck_rise, ld_fall, ld_rise, clr_fall;
  logic do_load;

  // Synchronizer chain: stage 0 samples the pins, later stages shift along.
  assign sync_d[0] = {CLR_6, LD_5, SDI_4, CLK_3};
  for (genvar g = 1; g < SYNC_STAGES; g++) begin : g_sync
    assign sync_d[g] = sync_q[g-1];
  end

  assign pins_s = sync_q[SYNC_STAGES-1];
  assign sck_s  = pins_s[PIN_SCK];
  assign sdi_s  = pins_s[PIN_SDI];
  assign ld_s   = pins_s[PIN_LD];
  assign clr_s  = pins_s[PIN_CLR];
  assign dly_d  = {clr_s, ld_s, sck_s};

  assign sck_rise = sck_s & ~dly_q[0];
  assign ld_fall  = ~ld_s & dly_q[1];
  assign ld_rise  = ld_s & ~dly_q[1];
  assign clr_fall = ~clr_s & dly_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      dly_q   <= '1;
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      code_q  <= RESET_CODE;
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      load_q  <= load_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
    end
  end

  // Shift happens before a same-cycle load so the load sees the newest bit.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    load_d  = 1'b0;
    clr_d   = 1'b0;
    err_d   = 1'b0;
    do_load = 1'b0;

    if (state_q != HOLD && sck_rise) begin
      shreg_d = {shreg_q[CODE_W-2:0], sdi_s};
      cnt_d   = (cnt_q == MAX_CNT) ? MAX_CNT : cnt_q + CNT_W'(1);
      state_d = SHIFT;
    end

    if (state_q != HOLD && ld_fall) begin
      do_load = 1'b1;
      state_d = HOLD;
    end else if (ld_rise) begin
      cnt_d   = '0;
      state_d = IDLE;
    end

    // An active CLR overrides any load of the latch.
    if (!clr_s) begin
      code_d = RESET_CODE;
      clr_d  = clr_fall;
    end else if (do_load) begin
      code_d = shreg_d;
      load_d = 1'b1;
      err_d  = (cnt_d != FULL_CNT);
    end
  end

  assign dac_code    = code_q;
  assign load_strobe = load_q;
  assign clr_strobe  = clr_q;
  assign frame_err   = err_q;
  assign bit_cnt     = cnt_q;

endmodule

// File: tb/tb_dac7611_rx.sv
// Randomized bench for dac7611_rx against a bit-history reference model.
`timescale 1ns/1ps
module tb_dac7611_rx;

  localparam int unsigned SYNC_STAGES = 2;
  localparam logic [11:0] RESET_CODE  = 12'h000;
  localparam int unsigned HALF_SCLK   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        CLK_3, SDI_4, LD_5, CLR_6;
  logic [11:0] dac_code;
  logic        load_strobe, clr_strobe, frame_err;
  logic [3:0]  bit_cnt;

  dac7611_rx #(.SYNC_STAGES(SYNC_STAGES), .RESET_CODE(RESET_CODE)) dut (
    .clk(clk), .reset(reset), .CLK_3(CLK_3), .SDI_4(SDI_4), .LD_5(LD_5), .CLR_6(CLR_6),
    .dac_code(dac_code), .load_strobe(load_strobe), .clr_strobe(clr_strobe),
    .frame_err(frame_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_load = 0, n_clr = 0, n_err = 0, n_err_alone = 0;
  int exp_loads = 0, exp_clrs = 0, exp_errs = 0;

  // Reference model: every bit accepted since reset, and bits in this frame.
  bit hist[$];
  int frame_bits = 0;

  always @(negedge clk) begin
    if (load_strobe) n_load++;
    if (clr_strobe) n_clr++;
    if (frame_err) n_err++;
    if (frame_err && !load_strobe) n_err_alone++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] last12();
    logic [11:0] v;
    int n;
    v = '0;
    n = hist.size();
    for (int i = 0; i < 12; i++)
      if (n - 12 + i >= 0) v[11-i] = hist[n-12+i];
    return v;
  endfunction

  task automatic send_bit(input bit b);
    @(negedge clk);
    CLK_3 = 1'b0;
    SDI_4 = b;
    repeat (HALF_SCLK) @(negedge clk);
    CLK_3 = 1'b1;
    repeat (HALF_SCLK) @(negedge clk);
    hist.push_back(b);
    frame_bits++;
  endtask

  task automatic send_word(input logic [15:0] val, input int nbits);
    logic [15:0] v;
    v = val;
    for (int i = nbits - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_load(input bit with_bit, input bit b, input string tag);
    int lat;
    int exp_cnt;
    logic [11:0] exp;
    @(negedge clk);
    if (with_bit) begin
      CLK_3 = 1'b0;
      SDI_4 = b;
      repeat (HALF_SCLK) @(negedge clk);
      CLK_3 = 1'b1;
      hist.push_back(b);
      frame_bits++;
    end
    LD_5 = 1'b0;
    exp = last12();
    exp_cnt = (frame_bits > 15) ? 15 : frame_bits;
    exp_loads++;
    if (exp_cnt != 12) exp_errs++;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!load_strobe && lat < 20);
    chk({tag, "_latency"}, 32'(lat), 32'(SYNC_STAGES + 1));
    chk({tag, "_code"}, 32'(dac_code), 32'(exp));
    chk({tag, "_err"}, 32'(frame_err), 32'(exp_cnt != 12));
    chk({tag, "_cnt"}, 32'(bit_cnt), 32'(exp_cnt));
    // Serial clock activity while LD is low must not reach the shifter.
    CLK_3 = 1'b0;
    SDI_4 = 1'($urandom);
    repeat (HALF_SCLK) @(negedge clk);
    CLK_3 = 1'b1;
    repeat (2 * HALF_SCLK) @(negedge clk);
    chk({tag, "_hold_cnt"}, 32'(bit_cnt), 32'(exp_cnt));
    LD_5 = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    chk({tag, "_idle_cnt"}, 32'(bit_cnt), 32'd0);
    frame_bits = 0;
  endtask

  task automatic clr_pulse(input int ncyc, input string tag);
    int c0;
    c0 = n_clr;
    @(negedge clk);
    CLR_6 = 1'b0;
    repeat (ncyc) @(negedge clk);
    CLR_6 = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    exp_clrs++;
    chk({tag, "_clr_pulses"}, 32'(n_clr - c0), 32'd1);
    chk({tag, "_clr_code"}, 32'(dac_code), 32'(RESET_CODE));
  endtask

  task automatic apply_reset(input string tag);
    int c0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    c0 = n_load + n_clr + n_err;
    reset = 1'b0;
    hist.delete();
    frame_bits = 0;
    chk({tag, "_code"}, 32'(dac_code), 32'(RESET_CODE));
    chk({tag, "_cnt"}, 32'(bit_cnt), 32'd0);
    repeat (SYNC_STAGES + 1) @(negedge clk);
    chk({tag, "_quiet"}, 32'(n_load + n_clr + n_err - c0), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c_load, c_clr;
    int nb;
    bit wb;
    reset = 1'b1;
    CLK_3 = 1'b1;
    SDI_4 = 1'b0;
    LD_5  = 1'b1;
    CLR_6 = 1'b1;
    repeat (3) @(negedge clk);
    apply_reset("rst0");

    // Short frame of ones into an all-zero shift register.
    send_word(16'h03FF, 10);
    do_load(1'b0, 1'b0, "ten_ones");

    send_word(16'h0AAA, 12);
    do_load(1'b0, 1'b0, "aaa");

    send_word(16'h3555, 14);
    chk("long_cnt", 32'(bit_cnt), 32'd14);
    do_load(1'b0, 1'b0, "long14");

    send_word(16'h0AAA, 12);
    do_load(1'b0, 1'b0, "aaa2");
    fork
      clr_pulse(2, "clr2");
      send_word(16'h0123, 12);
    join
    do_load(1'b0, 1'b0, "after_clr");

    // LD and CLR fall together: clear wins.
    send_word(16'h0FFF, 12);
    c_load = n_load;
    c_clr  = n_clr;
    @(negedge clk);
    LD_5  = 1'b0;
    CLR_6 = 1'b0;
    repeat (SYNC_STAGES + 3) @(negedge clk);
    exp_clrs++;
    chk("tie_clr", 32'(n_clr - c_clr), 32'd1);
    chk("tie_load", 32'(n_load - c_load), 32'd0);
    chk("tie_code", 32'(dac_code), 32'(RESET_CODE));
    CLR_6 = 1'b1;
    repeat (4) @(negedge clk);
    chk("tie_hold_cnt", 32'(bit_cnt), 32'd12);
    LD_5 = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    chk("tie_idle_cnt", 32'(bit_cnt), 32'd0);
    frame_bits = 0;

    // Empty frame reloads the retained shift register.
    do_load(1'b0, 1'b0, "empty");

    send_word(16'h002D, 6);
    apply_reset("rst_mid");
    send_word(16'h00F0, 12);
    do_load(1'b0, 1'b0, "f0");

    // Shift and load detected in the same cycle.
    send_word(16'h0555, 11);
    do_load(1'b1, 1'b1, "same_cycle");

    for (int it = 0; it < 12; it++) begin
      nb = int'($urandom_range(0, 15));
      wb = 1'($urandom);
      if (nb >= 6 && $urandom_range(0, 1) == 1) begin
        fork
          clr_pulse(int'($urandom_range(2, 30)), "rnd_clr");
          send_word(16'($urandom), nb);
        join
      end else begin
        send_word(16'($urandom), nb);
      end
      do_load(wb, 1'($urandom), "rnd");
    end

    repeat (4) @(negedge clk);
    chk("total_loads", 32'(n_load), 32'(exp_loads));
    chk("total_clrs", 32'(n_clr), 32'(exp_clrs));
    chk("total_errs", 32'(n_err), 32'(exp_errs));
    chk("err_without_load", 32'(n_err_alone), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
